// File: rtl/set_key_controller.sv
// Alarm-clock SET button front end: two-flop synchroniser and per-key debounce,
// press and auto-repeat events, W1C capture register, maskable IRQ, Avalon-MM slave.
module set_key_controller #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [RCNT_W-1:0] RD_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RR_LAST  = RCNT_W'(REPEAT_RATE - 1);
  localparam logic [RCNT_W-1:0] RCNT_ONE = RCNT_W'(1);
  localparam logic [WIDTH-1:0]  KEY_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [WIDTH-1:0]            r_sync1;
  logic [WIDTH-1:0]            r_sync2;
  logic [WIDTH-1:0]            r_stable;
  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]            r_capture;
  logic [WIDTH-1:0]            r_irq_mask;
  logic [WIDTH-1:0]            r_repeat_en;
  logic                        r_irq;
  logic [31:0]                 r_readdata;
  state_t                      r_state;
  logic [RCNT_W-1:0]           r_rcnt;
  logic [IDX_W-1:0]            r_key;

  logic [WIDTH-1:0]            w_stable_nxt;
  logic [WIDTH-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]            w_press;
  logic [WIDTH-1:0]            w_press_en;
  logic                        w_track_ok;
  logic                        w_rep_fire;
  logic [WIDTH-1:0]            w_rep_evt;
  logic [WIDTH-1:0]            w_w1c;
  logic [31:0]                 w_rd_nxt;
  logic                        w_unused_wdata;

  function automatic logic [IDX_W-1:0] f_lowest(input logic [WIDTH-1:0] v);
    f_lowest = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = IDX_W'(i);
    end
  endfunction

  assign w_unused_wdata = ^writedata[31:WIDTH];

  // Per-key debounce: a mismatch must persist DEBOUNCE_CYCLES samples before it is accepted.
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] == DB_LAST) begin
          w_stable_nxt[i] = ~r_stable[i];
          w_cnt_nxt[i]    = '0;
        end else begin
          w_cnt_nxt[i]    = r_cnt[i] + CNT_ONE;
        end
      end else begin
        w_cnt_nxt[i] = '0;
      end
    end
  end

  assign w_press    = w_stable_nxt & ~r_stable;
  assign w_press_en = w_press & r_repeat_en;
  assign w_track_ok = r_stable[r_key] & r_repeat_en[r_key];

  // Synchroniser, debounced levels and debounce counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= in_port;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Repeat event fires on the tracked key at the terminal count, unless tracking just ended.
  always_comb begin
    w_rep_fire = 1'b0;
    case (r_state)
      ST_DELAY: begin
        if (w_track_ok && (r_rcnt == RD_LAST)) w_rep_fire = 1'b1;
        else                                   w_rep_fire = 1'b0;
      end
      ST_REPEAT: begin
        if (w_track_ok && (r_rcnt == RR_LAST)) w_rep_fire = 1'b1;
        else                                   w_rep_fire = 1'b0;
      end
      default: w_rep_fire = 1'b0;
    endcase
  end

  assign w_rep_evt = w_rep_fire ? (KEY_ONE << r_key) : '0;

  // Auto-repeat sequencer shared by all keys; only a fresh press can start tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rcnt  <= '0;
      r_key   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_press_en) begin
            r_key   <= f_lowest(w_stable_nxt & r_repeat_en);
            r_rcnt  <= '0;
            r_state <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (!w_track_ok) begin
            r_rcnt  <= '0;
            r_state <= ST_IDLE;
          end else if (r_rcnt == RD_LAST) begin
            r_rcnt  <= '0;
            r_state <= ST_REPEAT;
          end else begin
            r_rcnt  <= r_rcnt + RCNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (!w_track_ok) begin
            r_rcnt  <= '0;
            r_state <= ST_IDLE;
          end else if (r_rcnt == RR_LAST) begin
            r_rcnt  <= '0;
          end else begin
            r_rcnt  <= r_rcnt + RCNT_ONE;
          end
        end
        default: begin
          r_rcnt  <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // W1C mask and read mux for the register file.
  always_comb begin
    if (write && (address == 2'd1)) w_w1c = writedata[WIDTH-1:0];
    else                            w_w1c = '0;
    case (address)
      2'd0:    w_rd_nxt = 32'(r_stable);
      2'd1:    w_rd_nxt = 32'(r_capture);
      2'd2:    w_rd_nxt = 32'(r_irq_mask);
      2'd3:    w_rd_nxt = 32'(r_repeat_en);
      default: w_rd_nxt = 32'd0;
    endcase
  end

  // Capture (events override a same-cycle clear), control registers, irq and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_capture   <= '0;
      r_irq_mask  <= '0;
      r_repeat_en <= '0;
      r_irq       <= 1'b0;
      r_readdata  <= 32'd0;
    end else begin
      r_capture  <= (r_capture & ~w_w1c) | w_press | w_rep_evt;
      r_irq      <= |(r_capture & r_irq_mask);
      r_readdata <= w_rd_nxt;
      if (write && (address == 2'd2)) r_irq_mask <= writedata[WIDTH-1:0];
      else                            r_irq_mask <= r_irq_mask;
      if (write && (address == 2'd3)) r_repeat_en <= writedata[WIDTH-1:0];
      else                            r_repeat_en <= r_repeat_en;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: doc/set_key_controller.md
Name: set_key_controller

Overview:
- Front-end controller for the alarm clock's 5-bit SET push-button input port.
- Synchronises and debounces each button, generates press events, and auto-repeats a held button for fast time/alarm adjustment.
- Latches events in a write-1-to-clear capture register and raises a maskable IRQ.
- Avalon-MM slave on the system interconnect; read latency 1, no wait states.

Parameters:
- WIDTH, 5, number of SET buttons.
- DEBOUNCE_CYCLES, 500000, cycles a synced level must hold before it is accepted (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles a key must be held before the first auto-repeat event (0.5 s).
- REPEAT_RATE, 5000000, cycles between subsequent auto-repeat events (0.1 s).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- in_port  in  WIDTH  raw button levels, asynchronous, 1 = pressed.
- address  in  2  register select.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt.

Behaviour:
- Reset: all state is cleared while reset is high at a clk edge, including mid-debounce and mid-repeat. readdata=0, irq=0, sync flops=0, stable=0, counters=0, capture=0, irq_mask=0, repeat_en=0, FSM=IDLE.
- Synchroniser: 2 flops per bit on in_port, producing synced[i].
- Debounce, per bit:
  - If synced != stable, cnt increments.
  - If synced == stable, cnt clears to 0.
  - When cnt == DEBOUNCE_CYCLES-1 with a mismatch, stable toggles and cnt clears.
  - stable changes 2+DEBOUNCE_CYCLES cycles after a clean in_port transition.
  - Any glitch shorter than DEBOUNCE_CYCLES is rejected.
- Press event: stable[i] goes 0->1, one-cycle pulse. Release generates no event.
- Auto-repeat FSM, shared by all keys. Tracks key k = lowest-index bit with stable & repeat_en set.
  - IDLE: when a press event occurs on a repeat-enabled key, latch k, clear rcnt, go to DELAY.
  - DELAY: rcnt counts. At rcnt == REPEAT_DELAY-1, emit a repeat event on k, clear rcnt, go to REPEAT.
  - REPEAT: at rcnt == REPEAT_RATE-1, emit a repeat event on k and clear rcnt.
  - From DELAY or REPEAT: stable[k]=0 or repeat_en[k]=0 returns the FSM to IDLE with no event.
  - Presses of other keys while tracking are captured normally but never retarget the FSM.
- Capture register (WIDTH bits):
  - A bit is set by a press event or a repeat event on that bit.
  - A write to address 1 clears the bits where writedata is 1.
  - Set and clear on the same cycle: set wins.
- irq = |(capture & irq_mask), registered, so it asserts 1 cycle after the capture bit sets.
- Register map (reads zero-extended to 32 bits; readdata updates the cycle after address is presented, every cycle, independent of read):
  - 0: stable levels, read-only; writes ignored.
  - 1: capture, W1C.
  - 2: irq_mask, R/W.
  - 3: repeat_en, R/W.
- Writes take effect at the clk edge where write=1; writedata bits above WIDTH are ignored.
- Widths: cnt uses clog2(DEBOUNCE_CYCLES) bits; rcnt uses clog2(max(REPEAT_DELAY, REPEAT_RATE)) bits; counters never wrap past terminal values.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
1. Debounce: in_port[0] pulses high for 3 cycles, then 0 -> stable and capture stay 0. Hold high 10 cycles -> address 0 reads 0x01; capture reads 0x01 exactly 6 cycles after the edge plus 1 cycle read latency.
2. IRQ/W1C: irq_mask=0x1F, press bit 2 -> irq=1, capture=0x04. Write 0x04 to address 1 -> capture=0, irq=0 next cycle. Write 0x00 -> no change.
3. Auto-repeat: repeat_en=0x01, hold bit 0 for 60 cycles after stable -> repeat events at +20, +28, +36, +44, +52 (checked by clearing capture and sampling). Release -> FSM returns to IDLE, no further events.
4. Collision: issue a W1C of bit 0 on the same cycle as a repeat event on bit 0 -> capture bit 0 remains 1.
5. Multi-key: repeat_en=0x06, hold bits 1 and 2, pressing bit 1 first -> only bit 1 repeats; releasing bit 1 -> FSM returns to IDLE, bit 2 does not repeat until re-pressed.
6. Reset mid-operation: assert reset during DELAY with capture=0x03, mask=0x1F -> next cycle all registers 0, irq=0, readdata=0. A button still held re-debounces and produces a fresh press event 6 cycles after reset deasserts.
